navigate: RTL and testbench

- Responder to the maze-solving command FSM. Accepts the strt_hdng / strt_mv requests and executes the move.
- Holds `moving` during a heading change and reports mv_cmplt once at_hdng is reached.
- Straight moves: ramps forward speed up, then ends the move on an obstacle (hard brake) or on a newly opened side passage on the preferred side (gentle decel).
- Drives frwrd_spd and en_fusion into the PID/motor path.

---
 rtl/navigate.sv | 176 +++++++++++++++++
 tb/tb_navigate.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/navigate.sv
// navigate: motion responder for the maze-solving command FSM.
// Executes heading changes and straight moves. A straight move ramps the
// forward speed up from MIN_FRWRD toward MAX_FRWRD and ends either with a
// hard brake on an obstacle or with a gentle decel on a new side opening.
// frwrd_spd and en_fusion feed the PID/motor path.
module navigate #(
    parameter bit          FAST_SIM  = 1'b1,
    parameter logic [10:0] MIN_FRWRD = 11'h0D0,
    parameter logic [10:0] MAX_FRWRD = 11'h2A0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_hdng,
    input  logic        strt_mv,
    input  logic        stp_lft,
    input  logic        stp_rght,
    input  logic        hdng_rdy,
    input  logic        at_hdng,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    output logic        mv_cmplt,
    output logic        moving,
    output logic        en_fusion,
    output logic [10:0] frwrd_spd
);

    localparam int DATA_W = 11;

    // Per-update speed increment; the larger step shortens simulation runs.
    localparam logic [DATA_W-1:0] FRWRD_INC  = FAST_SIM ? 11'h018 : 11'h002;
    // Gentle decel removes twice the ramp step, hard brake four times.
    localparam logic [DATA_W-1:0] DECEL_STEP = FRWRD_INC << 1;
    localparam logic [DATA_W-1:0] BRAKE_STEP = FRWRD_INC << 2;
    // Sensor fusion is only trustworthy above half of the top speed.
    localparam logic [DATA_W-1:0] FUSION_THR = MAX_FRWRD >> 1;

    typedef enum logic [2:0] {
        IDLE,
        HDNG,
        RAMP,
        DECEL,
        BRAKE
    } state_t;

    state_t state;

    logic lft_opn_ff;
    logic rght_opn_ff;
    logic lft_rise;
    logic rght_rise;
    logic side_stop;

    // Saturating add: 12-bit intermediate so the carry is never lost,
    // result clamped to the top speed.
    function automatic logic [DATA_W-1:0] sat_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, MAX_FRWRD}) begin
            return MAX_FRWRD;
        end
        return sum[DATA_W-1:0];
    endfunction

    // Saturating subtract: a borrow out of the 12-bit intermediate means
    // the speed would go negative, so clamp to zero.
    function automatic logic [DATA_W-1:0] sat_sub(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[DATA_W]) begin
            return '0;
        end
        return diff[DATA_W-1:0];
    endfunction

    // Delay the wall-open flags by one cycle for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lft_opn_ff  <= 1'b0;
            rght_opn_ff <= 1'b0;
        end else begin
            lft_opn_ff  <= lft_opn;
            rght_opn_ff <= rght_opn;
        end
    end

    // Only a newly opened passage counts; one already open at the start of
    // a move produces no edge and therefore never stops it.
    assign lft_rise  = lft_opn & ~lft_opn_ff;
    assign rght_rise = rght_opn & ~rght_opn_ff;
    assign side_stop = (stp_lft & lft_rise) | (stp_rght & rght_rise);

    // Move sequencer: state, speed command and the registered handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            frwrd_spd <= '0;
            mv_cmplt  <= 1'b0;
            moving    <= 1'b0;
        end else begin
            mv_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    moving    <= 1'b0;
                    frwrd_spd <= '0;
                    if (strt_hdng) begin
                        state  <= HDNG;
                        moving <= 1'b1;
                    end else if (strt_mv) begin
                        state     <= RAMP;
                        moving    <= 1'b1;
                        frwrd_spd <= MIN_FRWRD;
                    end
                end

                HDNG: begin
                    frwrd_spd <= '0;
                    if (at_hdng) begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end
                end

                RAMP: begin
                    // Obstacle outranks a side opening; no speed step on an exit cycle.
                    if (!frwrd_opn) begin
                        state <= BRAKE;
                    end else if (side_stop) begin
                        state <= DECEL;
                    end else if (hdng_rdy) begin
                        frwrd_spd <= sat_add(frwrd_spd, FRWRD_INC);
                    end
                end

                DECEL: begin
                    if (frwrd_spd == '0) begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end else if (!frwrd_opn) begin
                        state <= BRAKE;
                    end else if (hdng_rdy) begin
                        frwrd_spd <= sat_sub(frwrd_spd, DECEL_STEP);
                    end
                end

                BRAKE: begin
                    if (frwrd_spd == '0) begin
                        state    <= IDLE;
                        moving   <= 1'b0;
                        mv_cmplt <= 1'b1;
                    end else if (hdng_rdy) begin
                        frwrd_spd <= sat_sub(frwrd_spd, BRAKE_STEP);
                    end
                end

                default: begin
                    state     <= IDLE;
                    moving    <= 1'b0;
                    frwrd_spd <= '0;
                end
            endcase
        end
    end

    // Fusion enable compares the registered speed, so it is glitch-free.
    assign en_fusion = (frwrd_spd > FUSION_THR);

endmodule

// File: tb/tb_navigate.sv
// tb_navigate: directed bench for navigate with FAST_SIM=1
// (ramp step 0x18, decel step 0x30, brake step 0x60).
module tb_navigate;

    logic        clk;
    logic        rst_n;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic        hdng_rdy;
    logic        at_hdng;
    logic        lft_opn;
    logic        rght_opn;
    logic        frwrd_opn;
    logic        mv_cmplt;
    logic        moving;
    logic        en_fusion;
    logic [10:0] frwrd_spd;

    int total;
    int bad;
    int exp_spd;

    navigate #(
        .FAST_SIM (1'b1),
        .MIN_FRWRD(11'h0D0),
        .MAX_FRWRD(11'h2A0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .strt_hdng(strt_hdng),
        .strt_mv  (strt_mv),
        .stp_lft  (stp_lft),
        .stp_rght (stp_rght),
        .hdng_rdy (hdng_rdy),
        .at_hdng  (at_hdng),
        .lft_opn  (lft_opn),
        .rght_opn (rght_opn),
        .frwrd_opn(frwrd_opn),
        .mv_cmplt (mv_cmplt),
        .moving   (moving),
        .en_fusion(en_fusion),
        .frwrd_spd(frwrd_spd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Check the three main outputs plus en_fusion derived from the speed.
    task automatic chk_out(input string tag, input int spd, input bit mov, input bit cmp);
        chk({tag, ".spd"}, {21'd0, frwrd_spd}, spd);
        chk({tag, ".moving"}, {31'd0, moving}, {31'd0, mov});
        chk({tag, ".mv_cmplt"}, {31'd0, mv_cmplt}, {31'd0, cmp});
        chk({tag, ".en_fusion"}, {31'd0, en_fusion}, (spd > 'h150) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ramp(input int s);
        return (s + 'h18 > 'h2A0) ? 'h2A0 : s + 'h18;
    endfunction

    function automatic int down(input int s, input int step);
        return (s > step) ? s - step : 0;
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        strt_hdng = 1'b0;
        strt_mv   = 1'b1;
        stp_lft   = 1'b0;
        stp_rght  = 1'b0;
        hdng_rdy  = 1'b0;
        at_hdng   = 1'b0;
        lft_opn   = 1'b0;
        rght_opn  = 1'b0;
        frwrd_opn = 1'b1;

        // Reset held two clocks with strt_mv asserted
        tick();
        tick();
        chk_out("reset", 0, 1'b0, 1'b0);
        strt_mv = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk_out("post_reset", 0, 1'b0, 1'b0);

        // Heading change
        strt_hdng = 1'b1;
        tick();
        strt_hdng = 1'b0;
        chk_out("hdng_start", 0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk_out("hdng_wait", 0, 1'b1, 1'b0);
        end
        at_hdng = 1'b1;
        tick();
        at_hdng = 1'b0;
        chk_out("hdng_done", 0, 1'b0, 1'b1);
        tick();
        chk_out("hdng_idle", 0, 1'b0, 1'b0);

        // Ramp to saturation, then obstacle brake
        hdng_rdy = 1'b1;
        strt_mv  = 1'b1;
        tick();
        strt_mv = 1'b0;
        exp_spd = 'h0D0;
        chk_out("ramp_start", exp_spd, 1'b1, 1'b0);
        for (int i = 1; i <= 21; i++) begin
            tick();
            exp_spd = ramp(exp_spd);
            chk_out("ramp", exp_spd, 1'b1, 1'b0);
        end
        frwrd_opn = 1'b0;
        tick();
        chk_out("brake_enter", 'h2A0, 1'b1, 1'b0);
        exp_spd = 'h2A0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_spd = down(exp_spd, 'h60);
            chk_out("brake", exp_spd, 1'b1, 1'b0);
        end
        tick();
        chk_out("brake_done", 0, 1'b0, 1'b1);
        tick();
        chk_out("brake_idle", 0, 1'b0, 1'b0);
        frwrd_opn = 1'b1;

        // Left-opening stop from top speed
        stp_lft = 1'b1;
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        exp_spd = 'h0D0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_spd = ramp(exp_spd);
            chk_out("lft_ramp", exp_spd, 1'b1, 1'b0);
        end
        lft_opn = 1'b1;
        tick();
        chk_out("decel_enter", 'h2A0, 1'b1, 1'b0);
        exp_spd = 'h2A0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            exp_spd = down(exp_spd, 'h30);
            chk_out("decel", exp_spd, 1'b1, 1'b0);
        end
        tick();
        chk_out("decel_done", 0, 1'b0, 1'b1);
        tick();
        chk_out("decel_idle", 0, 1'b0, 1'b0);

        // Opening already present at strt_mv is ignored
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        exp_spd = 'h0D0;
        chk_out("open_start", exp_spd, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_spd = ramp(exp_spd);
            chk_out("open_ignored", exp_spd, 1'b1, 1'b0);
        end
        lft_opn = 1'b0;
        tick();
        exp_spd = ramp(exp_spd);
        chk_out("open_close", exp_spd, 1'b1, 1'b0);
        lft_opn = 1'b1;
        tick();
        chk_out("open_reopen", 'h160, 1'b1, 1'b0);
        exp_spd = 'h160;
        for (int i = 0; i < 20 && exp_spd != 0; i++) begin
            tick();
            exp_spd = down(exp_spd, 'h30);
            chk_out("open_decel", exp_spd, 1'b1, 1'b0);
        end
        tick();
        chk_out("open_done", 0, 1'b0, 1'b1);
        tick();
        stp_lft = 1'b0;
        lft_opn = 1'b0;

        // strt_hdng and strt_mv together: heading wins
        strt_hdng = 1'b1;
        strt_mv   = 1'b1;
        tick();
        strt_hdng = 1'b0;
        strt_mv   = 1'b0;
        chk_out("both_start", 0, 1'b1, 1'b0);
        tick();
        chk_out("both_hold", 0, 1'b1, 1'b0);
        at_hdng = 1'b1;
        tick();
        at_hdng = 1'b0;
        chk_out("both_done", 0, 1'b0, 1'b1);
        tick();

        // Opening edge and obstacle in the same cycle: brake wins
        stp_rght = 1'b1;
        strt_mv  = 1'b1;
        tick();
        strt_mv = 1'b0;
        exp_spd = 'h0D0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_spd = ramp(exp_spd);
        end
        chk_out("combo_ramp", 'h118, 1'b1, 1'b0);
        rght_opn  = 1'b1;
        frwrd_opn = 1'b0;
        tick();
        chk_out("combo_enter", 'h118, 1'b1, 1'b0);
        tick();
        chk_out("combo_b1", 'h0B8, 1'b1, 1'b0);
        tick();
        chk_out("combo_b2", 'h058, 1'b1, 1'b0);
        tick();
        chk_out("combo_b3", 0, 1'b1, 1'b0);
        tick();
        chk_out("combo_done", 0, 1'b0, 1'b1);
        tick();
        stp_rght  = 1'b0;
        rght_opn  = 1'b0;
        frwrd_opn = 1'b1;

        // strt_mv during RAMP, frozen speed, synchronous reset mid-move
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        tick();
        chk_out("remv_ramp", 'h0E8, 1'b1, 1'b0);
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        chk_out("remv_noreload", 'h100, 1'b1, 1'b0);
        hdng_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("frozen", 'h100, 1'b1, 1'b0);
        end
        hdng_rdy = 1'b1;
        rst_n    = 1'b0;
        #2;
        chk_out("rst_sync_wait", 'h100, 1'b1, 1'b0);
        tick();
        chk_out("rst_abort", 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("rst_no_cmplt", 0, 1'b0, 1'b0);
        tick();
        chk_out("rst_idle", 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
